// File: rtl/vend_ctrl_param.sv
// Parametrised vending controller: supplier-loaded price/stock tables, cents coin balance,
// one-hot selection, single-cycle vend and greedy one-coin-per-cycle change return.
module vend_ctrl_param #(
    parameter int N_ITEMS = 6,
    parameter int COUNT_W = 4,
    parameter int PRICE_W = 8,
    parameter int BAL_W   = 10,
    localparam int IDX_W  = $clog2(N_ITEMS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sup_valid,
    input  logic [IDX_W-1:0]   sup_item,
    input  logic [COUNT_W-1:0] sup_count,
    input  logic [PRICE_W-1:0] sup_price,
    input  logic [1:0]         coin,
    input  logic [N_ITEMS-1:0] sel,
    input  logic               enter,
    input  logic               cancel,
    output logic               vend_valid,
    output logic [IDX_W-1:0]   vend_item,
    output logic [1:0]         change_coin,
    output logic               coin_reject,
    output logic               sup_ack,
    output logic [2:0]         status,
    output logic [BAL_W-1:0]   balance,
    output logic [PRICE_W-1:0] price_disp
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SELECT = 2'd1;
    localparam logic [1:0] S_VEND   = 2'd2;
    localparam logic [1:0] S_CHANGE = 2'd3;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_SELECTED  = 3'd1;
    localparam logic [2:0] ST_SOLD_OUT  = 3'd2;
    localparam logic [2:0] ST_INSUFF    = 3'd3;
    localparam logic [2:0] ST_MULTI_SEL = 3'd4;
    localparam logic [2:0] ST_VENDING   = 3'd5;
    localparam logic [2:0] ST_CHANGE    = 3'd6;
    localparam logic [2:0] ST_BAD_WRITE = 3'd7;

    // Common compare width: one bit wider than either operand so sums never wrap.
    localparam int CW = ((BAL_W > PRICE_W) ? BAL_W : PRICE_W) + 1;
    localparam logic [CW-1:0] BAL_MAX = CW'((1 << BAL_W) - 1);

    logic [1:0]         state;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   sel_idx;
    logic [PRICE_W-1:0] price_tab [N_ITEMS];
    logic [COUNT_W-1:0] count_tab [N_ITEMS];

    logic [CW-1:0]      coin_val;
    logic [CW-1:0]      bal_sum;
    logic               coin_fits;
    logic               sup_bad;
    logic [BAL_W-1:0]   bal_new;
    logic [BAL_W-1:0]   bal_vend;
    logic [BAL_W-1:0]   chg_amt;
    logic [BAL_W-1:0]   bal_chg;
    logic [1:0]         chg_code;
    logic [PRICE_W-1:0] cur_price;
    logic [COUNT_W-1:0] cur_count;

    assign cur_price = price_tab[idx];
    assign cur_count = count_tab[idx];

    always_comb begin
        case (coin)
            2'b01:   coin_val = CW'(5);
            2'b10:   coin_val = CW'(10);
            2'b11:   coin_val = CW'(25);
            default: coin_val = '0;
        endcase
    end

    assign bal_sum   = CW'(balance) + coin_val;
    assign coin_fits = (bal_sum <= BAL_MAX);
    assign bal_new   = (coin != 2'b00 && coin_fits) ? bal_sum[BAL_W-1:0] : balance;
    // Only reached after the enter check proved balance >= price.
    assign bal_vend  = BAL_W'(CW'(balance) - CW'(cur_price));

    always_comb begin
        if (balance >= BAL_W'(25)) begin
            chg_code = 2'b11;
            chg_amt  = BAL_W'(25);
        end else if (balance >= BAL_W'(10)) begin
            chg_code = 2'b10;
            chg_amt  = BAL_W'(10);
        end else begin
            chg_code = 2'b01;
            chg_amt  = BAL_W'(5);
        end
    end

    assign bal_chg = (balance > chg_amt) ? balance - chg_amt : '0;

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < N_ITEMS; i++)
            if (sel[i]) sel_idx = IDX_W'(i);
    end

    assign sup_bad = (int'(sup_item) >= N_ITEMS) || ((sup_price % PRICE_W'(5)) != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            idx         <= '0;
            vend_valid  <= 1'b0;
            vend_item   <= '0;
            change_coin <= 2'b00;
            coin_reject <= 1'b0;
            sup_ack     <= 1'b0;
            status      <= ST_IDLE;
            balance     <= '0;
            price_disp  <= '0;
            for (int i = 0; i < N_ITEMS; i++) begin
                price_tab[i] <= '0;
                count_tab[i] <= '0;
            end
        end else begin
            vend_valid  <= 1'b0;
            vend_item   <= '0;
            change_coin <= 2'b00;
            coin_reject <= 1'b0;
            sup_ack     <= 1'b0;
            case (state)
                S_IDLE, S_SELECT: begin
                    coin_reject <= (coin != 2'b00) && !coin_fits;
                    balance     <= bal_new;
                    // Priority: cancel, enter (SELECT), supplier write (IDLE), selection.
                    if (cancel) begin
                        price_disp <= '0;
                        if (bal_new != '0) begin
                            state  <= S_CHANGE;
                            status <= ST_CHANGE;
                        end else begin
                            state  <= S_IDLE;
                            status <= ST_IDLE;
                        end
                    end else if (state == S_SELECT && enter) begin
                        // Compare against the pre-coin balance.
                        if (cur_count == '0)
                            status <= ST_SOLD_OUT;
                        else if (CW'(balance) < CW'(cur_price))
                            status <= ST_INSUFF;
                        else
                            state <= S_VEND;
                    end else if (state == S_IDLE && sup_valid) begin
                        if (balance == '0) begin
                            if (sup_bad) begin
                                status <= ST_BAD_WRITE;
                            end else begin
                                price_tab[sup_item] <= sup_price;
                                count_tab[sup_item] <= sup_count;
                                sup_ack             <= 1'b1;
                                status              <= ST_IDLE;
                            end
                        end
                    end else if (sel != '0) begin
                        if ($onehot(sel)) begin
                            idx        <= sel_idx;
                            price_disp <= price_tab[sel_idx];
                            status     <= ST_SELECTED;
                            state      <= S_SELECT;
                        end else begin
                            status <= ST_MULTI_SEL;
                        end
                    end
                end
                S_VEND: begin
                    coin_reject    <= (coin != 2'b00);
                    vend_valid     <= 1'b1;
                    vend_item      <= idx;
                    count_tab[idx] <= cur_count - COUNT_W'(1);
                    balance        <= bal_vend;
                    status         <= ST_VENDING;
                    price_disp     <= '0;
                    state          <= (bal_vend != '0) ? S_CHANGE : S_IDLE;
                end
                default: begin
                    coin_reject <= (coin != 2'b00);
                    change_coin <= chg_code;
                    balance     <= bal_chg;
                    if (bal_chg == '0) begin
                        state  <= S_IDLE;
                        status <= ST_IDLE;
                    end else begin
                        status <= ST_CHANGE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vend_ctrl_param.sv
// Bench for vend_ctrl_param: directed vector table, randomized traffic against a
// behavioural model, and a narrow-balance instance for coin overflow.
module tb_vend_ctrl_param;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sup_valid = 1'b0;
    logic [2:0] sup_item = '0;
    logic [3:0] sup_count = '0;
    logic [7:0] sup_price = '0;
    logic [1:0] coin = '0;
    logic [5:0] sel = '0;
    logic       enter = 1'b0;
    logic       cancel = 1'b0;

    logic       vend_valid;
    logic [2:0] vend_item;
    logic [1:0] change_coin;
    logic       coin_reject;
    logic       sup_ack;
    logic [2:0] status;
    logic [9:0] balance;
    logic [7:0] price_disp;

    logic [1:0] coin6 = '0;
    logic       vv6, cr6, ack6;
    logic [2:0] vi6, st6;
    logic [1:0] cc6;
    logic [5:0] bal6;
    logic [7:0] pd6;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    vend_ctrl_param dut (
        .clk(clk), .rst(rst), .sup_valid(sup_valid), .sup_item(sup_item),
        .sup_count(sup_count), .sup_price(sup_price), .coin(coin), .sel(sel),
        .enter(enter), .cancel(cancel), .vend_valid(vend_valid), .vend_item(vend_item),
        .change_coin(change_coin), .coin_reject(coin_reject), .sup_ack(sup_ack),
        .status(status), .balance(balance), .price_disp(price_disp)
    );

    vend_ctrl_param #(.BAL_W(6)) dut6 (
        .clk(clk), .rst(rst), .sup_valid(1'b0), .sup_item(3'd0),
        .sup_count(4'd0), .sup_price(8'd0), .coin(coin6), .sel(6'd0),
        .enter(1'b0), .cancel(1'b0), .vend_valid(vv6), .vend_item(vi6),
        .change_coin(cc6), .coin_reject(cr6), .sup_ack(ack6),
        .status(st6), .balance(bal6), .price_disp(pd6)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int M_IDLE = 0, M_SEL = 1, M_VEND = 2, M_CHG = 3;
    localparam int MAX_BAL = 1023;
    int m_mode, m_bal, m_idx, m_st, m_pd;
    int m_price [6];
    int m_cnt [6];
    int m_chq [$];
    int e_vv, e_vi, e_cc, e_cr, e_ack;

    function automatic int coin_cents(input logic [1:0] c);
        return (c == 2'b01) ? 5 : (c == 2'b10) ? 10 : (c == 2'b11) ? 25 : 0;
    endfunction

    function automatic int coin_code(input int cents);
        return (cents == 25) ? 3 : (cents == 10) ? 2 : (cents == 5) ? 1 : 0;
    endfunction

    // Greedy refund worked out up front as a list of coins.
    task automatic load_change(input int b);
        int r;
        m_chq.delete();
        repeat (b / 25) m_chq.push_back(25);
        r = b % 25;
        repeat (r / 10) m_chq.push_back(10);
        r = r % 10;
        repeat (r / 5) m_chq.push_back(5);
    endtask

    task automatic model_step();
        int cv, nb, c;
        e_vv = 0; e_vi = 0; e_cc = 0; e_cr = 0; e_ack = 0;
        if (rst) begin
            m_mode = M_IDLE; m_bal = 0; m_idx = 0; m_st = 0; m_pd = 0;
            for (int i = 0; i < 6; i++) begin m_price[i] = 0; m_cnt[i] = 0; end
            m_chq.delete();
            return;
        end
        cv = coin_cents(coin);
        case (m_mode)
            M_IDLE, M_SEL: begin
                nb = (m_bal + cv <= MAX_BAL) ? m_bal + cv : m_bal;
                if (cv != 0 && m_bal + cv > MAX_BAL) e_cr = 1;
                if (cancel) begin
                    m_pd = 0;
                    if (nb > 0) begin m_mode = M_CHG; m_st = 6; load_change(nb); end
                    else begin m_mode = M_IDLE; m_st = 0; end
                end else if (m_mode == M_SEL && enter) begin
                    if (m_cnt[m_idx] == 0) m_st = 2;
                    else if (m_bal < m_price[m_idx]) m_st = 3;
                    else m_mode = M_VEND;
                end else if (m_mode == M_IDLE && sup_valid) begin
                    if (m_bal == 0) begin
                        if (int'(sup_item) >= 6 || int'(sup_price) % 5 != 0) m_st = 7;
                        else begin
                            m_price[sup_item] = int'(sup_price);
                            m_cnt[sup_item] = int'(sup_count);
                            e_ack = 1; m_st = 0;
                        end
                    end
                end else if (sel != 0) begin
                    if ($countones(sel) == 1) begin
                        for (int i = 0; i < 6; i++) if (sel[i]) m_idx = i;
                        m_pd = m_price[m_idx]; m_st = 1; m_mode = M_SEL;
                    end else m_st = 4;
                end
                m_bal = nb;
            end
            M_VEND: begin
                e_cr = (cv != 0);
                e_vv = 1; e_vi = m_idx;
                m_cnt[m_idx]--;
                m_bal -= m_price[m_idx];
                m_st = 5; m_pd = 0;
                if (m_bal > 0) begin m_mode = M_CHG; load_change(m_bal); end
                else m_mode = M_IDLE;
            end
            default: begin
                e_cr = (cv != 0);
                c = (m_chq.size() > 0) ? m_chq.pop_front() : m_bal;
                e_cc = coin_code(c);
                m_bal -= c;
                if (m_chq.size() == 0) begin m_mode = M_IDLE; m_st = 0; end
                else m_st = 6;
            end
        endcase
    endtask

    // Apply current inputs for one clock, then compare every output with the model.
    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        check("vend_valid", 32'(vend_valid), 32'(e_vv));
        check("vend_item", 32'(vend_item), 32'(e_vi));
        check("change_coin", 32'(change_coin), 32'(e_cc));
        check("coin_reject", 32'(coin_reject), 32'(e_cr));
        check("sup_ack", 32'(sup_ack), 32'(e_ack));
        check("status", 32'(status), 32'(m_st));
        check("balance", 32'(balance), 32'(m_bal));
        check("price_disp", 32'(price_disp), 32'(m_pd));
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       r, sv;
        logic [2:0] si;
        logic [3:0] sc;
        logic [7:0] sp;
        logic [1:0] cn;
        logic [5:0] sl;
        logic       en, ca;
        logic [28:0] exp;  // {vv, vi, cc, cr, ack, status, balance, price_disp}
    } vec_t;

    vec_t vecs [$];

    function automatic vec_t mk(input int r, input int sv, input int si, input int sc,
                                input int sp, input int cn, input int sl, input int en,
                                input int ca, input int vv, input int vi, input int cc,
                                input int cr, input int ak, input int st, input int bl,
                                input int pd);
        vec_t v;
        v.r = (r != 0); v.sv = (sv != 0); v.si = 3'(si); v.sc = 4'(sc); v.sp = 8'(sp);
        v.cn = 2'(cn); v.sl = 6'(sl); v.en = (en != 0); v.ca = (ca != 0);
        v.exp = {1'(vv), 3'(vi), 2'(cc), 1'(cr), 1'(ak), 3'(st), 10'(bl), 8'(pd)};
        return v;
    endfunction

    initial begin
        //                r sv si sc  sp cn sel       en ca   vv vi cc cr ak st  bal  pd
        vecs.push_back(mk(1, 0, 0, 0,  0, 0, 0,        0, 0,  0, 0, 0, 0, 0, 0,   0,  0)); // reset
        vecs.push_back(mk(0, 1, 2, 3, 75, 0, 0,        0, 0,  0, 0, 0, 0, 1, 0,   0,  0)); // load slot 2
        vecs.push_back(mk(0, 0, 0, 0,  0, 2, 0,        0, 0,  0, 0, 0, 0, 0, 0,  10,  0));
        vecs.push_back(mk(0, 1, 1, 2, 50, 0, 0,        0, 0,  0, 0, 0, 0, 0, 0,  10,  0)); // write with credit: ignored
        vecs.push_back(mk(0, 0, 0, 0,  0, 0, 0,        0, 1,  0, 0, 0, 0, 0, 6,  10,  0));
        vecs.push_back(mk(0, 0, 0, 0,  0, 0, 0,        0, 0,  0, 0, 2, 0, 0, 0,   0,  0));
        vecs.push_back(mk(0, 1, 6, 1, 10, 0, 0,        0, 0,  0, 0, 0, 0, 0, 7,   0,  0)); // slot out of range
        vecs.push_back(mk(0, 1, 3, 1, 33, 0, 0,        0, 0,  0, 0, 0, 0, 0, 7,   0,  0)); // price not x5
        vecs.push_back(mk(0, 1, 3, 2,  0, 0, 0,        0, 0,  0, 0, 0, 0, 1, 0,   0,  0));
        vecs.push_back(mk(0, 1, 4, 5, 60, 0, 0,        0, 0,  0, 0, 0, 0, 1, 0,   0,  0));
        vecs.push_back(mk(0, 1, 5, 0, 40, 0, 0,        0, 0,  0, 0, 0, 0, 1, 0,   0,  0));
        vecs.push_back(mk(0, 0, 0, 0,  0, 3, 0,        0, 0,  0, 0, 0, 0, 0, 0,  25,  0));
        vecs.push_back(mk(0, 0, 0, 0,  0, 3, 0,        0, 0,  0, 0, 0, 0, 0, 0,  50,  0));
        vecs.push_back(mk(0, 0, 0, 0,  0, 3, 0,        0, 0,  0, 0, 0, 0, 0, 0,  75,  0));
        vecs.push_back(mk(0, 0, 0, 0,  0, 0, 'b000100, 0, 0,  0, 0, 0, 0, 0, 1,  75, 75));
        vecs.push_back(mk(0, 0, 0, 0,  0, 0, 0,        1, 0,  0, 0, 0, 0, 0, 1,  75, 75));
        vecs.push_back(mk(0, 0, 0, 0,  0, 0, 0,        0, 0,  1, 2, 0, 0, 0, 5,   0,  0)); // exact-price vend
        vecs.push_back(mk(0, 0, 0, 0,  0, 3, 0,        0, 0,  0, 0, 0, 0, 0, 5,  25,  0));
        vecs.push_back(mk(0, 0, 0, 0,  0, 3, 0,        0, 0,  0, 0, 0, 0, 0, 5,  50,  0));
        vecs.push_back(mk(0, 0, 0, 0,  0, 3, 0,        0, 0,  0, 0, 0, 0, 0, 5,  75,  0));
        vecs.push_back(mk(0, 0, 0, 0,  0, 3, 0,        0, 0,  0, 0, 0, 0, 0, 5, 100,  0));
        vecs.push_back(mk(0, 0, 0, 0,  0, 0, 'b010000, 0, 0,  0, 0, 0, 0, 0, 1, 100, 60));
        vecs.push_back(mk(0, 0, 0, 0,  0, 0, 0,        1, 0,  0, 0, 0, 0, 0, 1, 100, 60));
        vecs.push_back(mk(0, 0, 0, 0,  0, 0, 0,        0, 0,  1, 4, 0, 0, 0, 5,  40,  0));
        vecs.push_back(mk(0, 0, 0, 0,  0, 0, 0,        0, 0,  0, 0, 3, 0, 0, 6,  15,  0)); // change 25
        vecs.push_back(mk(0, 0, 0, 0,  0, 0, 0,        0, 0,  0, 0, 2, 0, 0, 6,   5,  0)); // change 10
        vecs.push_back(mk(0, 0, 0, 0,  0, 0, 0,        0, 0,  0, 0, 1, 0, 0, 0,   0,  0)); // change 5
        vecs.push_back(mk(0, 0, 0, 0,  0, 0, 'b000110, 0, 0,  0, 0, 0, 0, 0, 4,   0,  0)); // multi-select
        vecs.push_back(mk(0, 0, 0, 0,  0, 3, 0,        0, 0,  0, 0, 0, 0, 0, 4,  25,  0));
        vecs.push_back(mk(0, 0, 0, 0,  0, 3, 0,        0, 0,  0, 0, 0, 0, 0, 4,  50,  0));
        vecs.push_back(mk(0, 0, 0, 0,  0, 0, 'b100000, 0, 0,  0, 0, 0, 0, 0, 1,  50, 40));
        vecs.push_back(mk(0, 0, 0, 0,  0, 0, 0,        1, 0,  0, 0, 0, 0, 0, 2,  50, 40)); // sold out
        vecs.push_back(mk(0, 0, 0, 0,  0, 0, 'b000100, 0, 0,  0, 0, 0, 0, 0, 1,  50, 75));
        vecs.push_back(mk(0, 0, 0, 0,  0, 0, 0,        1, 0,  0, 0, 0, 0, 0, 3,  50, 75)); // insufficient
        vecs.push_back(mk(0, 0, 0, 0,  0, 0, 'b000110, 0, 0,  0, 0, 0, 0, 0, 4,  50, 75));
        vecs.push_back(mk(0, 0, 0, 0,  0, 0, 'b001000, 0, 0,  0, 0, 0, 0, 0, 1,  50,  0)); // free item
        vecs.push_back(mk(0, 0, 0, 0,  0, 0, 0,        1, 0,  0, 0, 0, 0, 0, 1,  50,  0));
        vecs.push_back(mk(0, 0, 0, 0,  0, 0, 0,        0, 0,  1, 3, 0, 0, 0, 5,  50,  0));
        vecs.push_back(mk(0, 0, 0, 0,  0, 0, 0,        0, 0,  0, 0, 3, 0, 0, 6,  25,  0));
        vecs.push_back(mk(0, 0, 0, 0,  0, 0, 0,        0, 0,  0, 0, 3, 0, 0, 0,   0,  0));
        vecs.push_back(mk(0, 0, 0, 0,  0, 3, 0,        0, 0,  0, 0, 0, 0, 0, 0,  25,  0));
        vecs.push_back(mk(0, 0, 0, 0,  0, 2, 0,        0, 0,  0, 0, 0, 0, 0, 0,  35,  0));
        vecs.push_back(mk(0, 0, 0, 0,  0, 1, 0,        0, 0,  0, 0, 0, 0, 0, 0,  40,  0));
        vecs.push_back(mk(0, 0, 0, 0,  0, 0, 'b000100, 0, 0,  0, 0, 0, 0, 0, 1,  40, 75));
        vecs.push_back(mk(0, 0, 0, 0,  0, 0, 0,        0, 1,  0, 0, 0, 0, 0, 6,  40,  0)); // cancel refund
        vecs.push_back(mk(0, 0, 0, 0,  0, 3, 0,        0, 0,  0, 0, 3, 1, 0, 6,  15,  0)); // coin in CHANGE
        vecs.push_back(mk(0, 0, 0, 0,  0, 0, 0,        0, 0,  0, 0, 2, 0, 0, 6,   5,  0));
        vecs.push_back(mk(0, 0, 0, 0,  0, 0, 0,        0, 0,  0, 0, 1, 0, 0, 0,   0,  0));
        vecs.push_back(mk(0, 0, 0, 0,  0, 3, 0,        0, 0,  0, 0, 0, 0, 0, 0,  25,  0));
        vecs.push_back(mk(0, 0, 0, 0,  0, 3, 0,        0, 0,  0, 0, 0, 0, 0, 0,  50,  0));
        vecs.push_back(mk(0, 0, 0, 0,  0, 0, 'b000100, 0, 0,  0, 0, 0, 0, 0, 1,  50, 75));
        vecs.push_back(mk(0, 0, 0, 0,  0, 3, 0,        1, 0,  0, 0, 0, 0, 0, 3,  75, 75)); // pre-coin compare
        vecs.push_back(mk(0, 0, 0, 0,  0, 0, 0,        1, 0,  0, 0, 0, 0, 0, 3,  75, 75));
        vecs.push_back(mk(0, 0, 0, 0,  0, 0, 0,        0, 0,  1, 2, 0, 0, 0, 5,   0,  0));
        vecs.push_back(mk(0, 0, 0, 0,  0, 3, 0,        0, 0,  0, 0, 0, 0, 0, 5,  25,  0));
        vecs.push_back(mk(0, 0, 0, 0,  0, 3, 0,        0, 0,  0, 0, 0, 0, 0, 5,  50,  0));
        vecs.push_back(mk(0, 0, 0, 0,  0, 2, 0,        0, 0,  0, 0, 0, 0, 0, 5,  60,  0));
        vecs.push_back(mk(0, 0, 0, 0,  0, 0, 0,        0, 1,  0, 0, 0, 0, 0, 6,  60,  0));
        vecs.push_back(mk(0, 0, 0, 0,  0, 0, 0,        0, 0,  0, 0, 3, 0, 0, 6,  35,  0));
        vecs.push_back(mk(1, 0, 0, 0,  0, 0, 0,        0, 0,  0, 0, 0, 0, 0, 0,   0,  0)); // rst mid-CHANGE
        vecs.push_back(mk(0, 0, 0, 0,  0, 0, 'b000100, 0, 0,  0, 0, 0, 0, 0, 1,   0,  0)); // price table cleared
        vecs.push_back(mk(0, 0, 0, 0,  0, 0, 0,        1, 0,  0, 0, 0, 0, 0, 2,   0,  0)); // count table cleared
        vecs.push_back(mk(0, 0, 0, 0,  0, 0, 0,        0, 1,  0, 0, 0, 0, 0, 0,   0,  0));
        vecs.push_back(mk(0, 1, 0, 1,  0, 0, 0,        0, 0,  0, 0, 0, 0, 1, 0,   0,  0));
        vecs.push_back(mk(0, 0, 0, 0,  0, 0, 'b000001, 0, 0,  0, 0, 0, 0, 0, 1,   0,  0));
        vecs.push_back(mk(0, 0, 0, 0,  0, 0, 0,        1, 0,  0, 0, 0, 0, 0, 1,   0,  0));
        vecs.push_back(mk(0, 0, 0, 0,  0, 3, 0,        0, 0,  1, 0, 0, 1, 0, 5,   0,  0)); // coin in VEND
        vecs.push_back(mk(0, 0, 0, 0,  0, 0, 'b000001, 0, 0,  0, 0, 0, 0, 0, 1,   0,  0));
        vecs.push_back(mk(0, 0, 0, 0,  0, 0, 0,        1, 0,  0, 0, 0, 0, 0, 2,   0,  0)); // count stays 0

        for (int k = 0; k < vecs.size(); k++) begin
            rst = vecs[k].r; sup_valid = vecs[k].sv; sup_item = vecs[k].si;
            sup_count = vecs[k].sc; sup_price = vecs[k].sp; coin = vecs[k].cn;
            sel = vecs[k].sl; enter = vecs[k].en; cancel = vecs[k].ca;
            step();
            check($sformatf("vector_%0d", k),
                  32'({vend_valid, vend_item, change_coin, coin_reject, sup_ack,
                       status, balance, price_disp}),
                  32'(vecs[k].exp));
        end

        // Randomized traffic; the model comparison inside step() does the checking.
        for (int k = 0; k < 3000; k++) begin
            rst       = ($urandom_range(0, 199) == 0);
            sup_valid = ($urandom_range(0, 7) == 0);
            sup_item  = 3'($urandom_range(0, 7));
            sup_count = 4'($urandom);
            sup_price = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'(5 * $urandom_range(0, 51));
            coin      = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
            case ($urandom_range(0, 9))
                6, 7, 8: sel = 6'(1 << $urandom_range(0, 5));
                9:       sel = 6'($urandom);
                default: sel = '0;
            endcase
            enter  = ($urandom_range(0, 3) == 0);
            cancel = ($urandom_range(0, 19) == 0);
            step();
        end

        // Narrow balance instance: 60 + 25 exceeds 63.
        rst = 1'b0; sup_valid = 1'b0; coin = '0; sel = '0; enter = 1'b0; cancel = 1'b0;
        coin6 = 2'b11; step();
        coin6 = 2'b11; step();
        coin6 = 2'b10; step();
        check("bal6_60", 32'(bal6), 32'd60);
        check("rej6_none", 32'(cr6), 32'd0);
        coin6 = 2'b11; step();
        check("rej6_overflow", 32'(cr6), 32'd1);
        check("bal6_hold", 32'(bal6), 32'd60);
        coin6 = 2'b01; step();
        check("rej6_overflow5", 32'(cr6), 32'd1);
        check("bal6_hold5", 32'(bal6), 32'd60);
        coin6 = 2'b00; step();
        check("rej6_idle", 32'(cr6), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
